// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 Hz VGA timing generator clocked by the 25 MHz
// pixel clock. Free-running horizontal/vertical counters are decoded into
// registered sync, blanking, coordinate and frame/animation pulse outputs,
// so every output changes on the same edge with no relative skew.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ANIM_DIV = 2
) (
    input  logic        VGA_clk,
    input  logic        reset,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        frame_tick,
    output logic        anim_tick,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC - 1;
    localparam int ANIM_W       = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [9:0]        h_cnt;
    logic [9:0]        v_cnt;
    logic [ANIM_W-1:0] anim_cnt;

    // Counters are widened to 32 bits so every comparison against the
    // integer timing constants happens at full width without truncation.
    logic [31:0] h_wide;
    logic [31:0] v_wide;
    logic [31:0] anim_wide;

    assign h_wide    = 32'(h_cnt);
    assign v_wide    = 32'(v_cnt);
    assign anim_wide = 32'(anim_cnt);

    logic h_last;
    logic v_last;
    logic hsync_d;
    logic vsync_d;
    logic video_on_d;
    logic frame_start;
    logic anim_last;

    // Decode of the current (pre-increment) counter position.
    always_comb begin
        h_last      = 1'b0;
        v_last      = 1'b0;
        hsync_d     = 1'b1;
        vsync_d     = 1'b1;
        video_on_d  = 1'b0;
        frame_start = 1'b0;
        anim_last   = 1'b0;

        h_last      = (h_wide == H_TOTAL - 1);
        v_last      = (v_wide == V_TOTAL - 1);
        hsync_d     = !((h_wide >= H_SYNC_START) && (h_wide <= H_SYNC_END));
        vsync_d     = !((v_wide >= V_SYNC_START) && (v_wide <= V_SYNC_END));
        video_on_d  = (h_wide < H_ACTIVE) && (v_wide < V_ACTIVE);
        frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
        anim_last   = (anim_wide == ANIM_DIV - 1);
    end

    // Pixel and line counters; the line counter only moves when the pixel
    // counter wraps, and both wrap together at the last pixel of the frame.
    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (h_last) begin
            h_cnt <= 10'd0;
            if (v_last) begin
                v_cnt <= 10'd0;
            end else begin
                v_cnt <= v_cnt + 10'd1;
            end
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Frame divider for the animation tick; advances once per frame start.
    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            anim_cnt <= '0;
        end else if (frame_start) begin
            if (anim_last) begin
                anim_cnt <= '0;
            end else begin
                anim_cnt <= anim_cnt + ANIM_W'(1);
            end
        end
    end

    // Output registers load the decode, lagging the counters by one cycle.
    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            pixel_x     <= 10'd0;
            pixel_y     <= 10'd0;
            frame_tick  <= 1'b0;
            anim_tick   <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            hsync      <= hsync_d;
            vsync      <= vsync_d;
            video_on   <= video_on_d;
            pixel_x    <= h_cnt;
            pixel_y    <= v_cnt;
            frame_tick <= frame_start;
            anim_tick  <= frame_start && anim_last;
            if (frame_start) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: drives three instances of vga_sync_gen and compares all
// outputs against a cycle-position model computed from the timing rules.
//   small : shrunken timing, ANIM_DIV=2, several whole frames and resets
//   big   : default 640x480 timing, first few lines after every reset
//   tiny  : one-pixel frame, ANIM_DIV=1, runs frame_count through its wrap
module tb_vga_sync_gen;

    localparam int S_HA = 20;
    localparam int S_HF = 3;
    localparam int S_HS = 5;
    localparam int S_HB = 4;
    localparam int S_VA = 10;
    localparam int S_VF = 2;
    localparam int S_VS = 2;
    localparam int S_VB = 3;
    localparam int S_AD = 2;

    logic clock   = 1'b0;
    logic clock_t = 1'b0;
    logic reset;
    logic reset_t;

    longint edges;
    longint edges_t;
    int     checks;
    int     errors;

    // Main clock shared by the small and big instances.
    always #5 clock = ~clock;

    // Faster clock for the wrap-test instance.
    always #1 clock_t = ~clock_t;

    logic        s_hsync, s_vsync, s_video_on, s_frame_tick, s_anim_tick;
    logic [9:0]  s_pixel_x, s_pixel_y;
    logic [15:0] s_frame_count;
    logic        b_hsync, b_vsync, b_video_on, b_frame_tick, b_anim_tick;
    logic [9:0]  b_pixel_x, b_pixel_y;
    logic [15:0] b_frame_count;
    logic        t_hsync, t_vsync, t_video_on, t_frame_tick, t_anim_tick;
    logic [9:0]  t_pixel_x, t_pixel_y;
    logic [15:0] t_frame_count;

    logic [40:0] s_obs;
    logic [40:0] b_obs;
    logic [40:0] t_obs;

    assign s_obs = {s_hsync, s_vsync, s_video_on, s_pixel_x, s_pixel_y,
                    s_frame_tick, s_anim_tick, s_frame_count};
    assign b_obs = {b_hsync, b_vsync, b_video_on, b_pixel_x, b_pixel_y,
                    b_frame_tick, b_anim_tick, b_frame_count};
    assign t_obs = {t_hsync, t_vsync, t_video_on, t_pixel_x, t_pixel_y,
                    t_frame_tick, t_anim_tick, t_frame_count};

    vga_sync_gen #(
        .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
        .ANIM_DIV (S_AD)
    ) dut_small (
        .VGA_clk     (clock),
        .reset       (reset),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .video_on    (s_video_on),
        .pixel_x     (s_pixel_x),
        .pixel_y     (s_pixel_y),
        .frame_tick  (s_frame_tick),
        .anim_tick   (s_anim_tick),
        .frame_count (s_frame_count)
    );

    vga_sync_gen dut_big (
        .VGA_clk     (clock),
        .reset       (reset),
        .hsync       (b_hsync),
        .vsync       (b_vsync),
        .video_on    (b_video_on),
        .pixel_x     (b_pixel_x),
        .pixel_y     (b_pixel_y),
        .frame_tick  (b_frame_tick),
        .anim_tick   (b_anim_tick),
        .frame_count (b_frame_count)
    );

    vga_sync_gen #(
        .H_ACTIVE (1), .H_FP (0), .H_SYNC (0), .H_BP (0),
        .V_ACTIVE (1), .V_FP (0), .V_SYNC (0), .V_BP (0),
        .ANIM_DIV (1)
    ) dut_tiny (
        .VGA_clk     (clock_t),
        .reset       (reset_t),
        .hsync       (t_hsync),
        .vsync       (t_vsync),
        .video_on    (t_video_on),
        .pixel_x     (t_pixel_x),
        .pixel_y     (t_pixel_y),
        .frame_tick  (t_frame_tick),
        .anim_tick   (t_anim_tick),
        .frame_count (t_frame_count)
    );

    // Expected outputs after a given number of rising edges since reset
    // release: the screen position is the edge index split into pixel,
    // line and frame by plain division.
    function automatic logic [40:0] model(input int ha, input int hf, input int hs, input int hb,
                                          input int va, input int vf, input int vs, input int vb,
                                          input int ad, input longint n_edges, input bit in_reset);
        longint lha, lhf, lhs, lva, lvf, lvs, lad;
        longint ht, vt, ft, n, h, v, fidx;
        logic   hs_n, vs_n, von, ftk, atk;
        lha = longint'(ha);
        lhf = longint'(hf);
        lhs = longint'(hs);
        lva = longint'(va);
        lvf = longint'(vf);
        lvs = longint'(vs);
        lad = longint'(ad);
        if (in_reset || n_edges == 64'sd0) begin
            return {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 16'd0};
        end
        ht   = lha + lhf + lhs + longint'(hb);
        vt   = lva + lvf + lvs + longint'(vb);
        ft   = ht * vt;
        n    = n_edges - 64'sd1;
        h    = n % ht;
        v    = (n / ht) % vt;
        fidx = n / ft;
        hs_n = !((h >= lha + lhf) && (h < lha + lhf + lhs));
        vs_n = !((v >= lva + lvf) && (v < lva + lvf + lvs));
        von  = (h < lha) && (v < lva);
        ftk  = (n % ft) == 64'sd0;
        atk  = ftk && (((fidx + 64'sd1) % lad) == 64'sd0);
        return {hs_n, vs_n, von, 10'(h), 10'(v), ftk, atk, 16'(fidx + 64'sd1)};
    endfunction

    // Compare both main-clock instances against the model.
    task automatic checkOutput();
        logic [40:0] exp_s;
        logic [40:0] exp_b;
        exp_s = model(S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_AD, edges, reset);
        exp_b = model(640, 16, 96, 48, 480, 10, 2, 33, 2, edges, reset);
        checks++;
        assert (s_obs === exp_s) else begin
            errors++;
            $error("[TB] FAIL small edge=%0d observed=%h expected=%h", edges, s_obs, exp_s);
        end
        checks++;
        assert (b_obs === exp_b) else begin
            errors++;
            $error("[TB] FAIL big edge=%0d observed=%h expected=%h", edges, b_obs, exp_b);
        end
    endtask

    // Compare the wrap-test instance against the model.
    task automatic checkTiny();
        logic [40:0] exp_t;
        exp_t = model(1, 0, 0, 0, 1, 0, 0, 0, 1, edges_t, reset_t);
        checks++;
        assert (t_obs === exp_t) else begin
            errors++;
            $error("[TB] FAIL tiny edge=%0d observed=%h expected=%h", edges_t, t_obs, exp_t);
        end
    endtask

    // Advance the main clock, checking every cycle on the falling edge.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            if (!reset) edges++;
            @(negedge clock);
            checkOutput();
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        edges   = 0;
        edges_t = 0;
        reset   = 1'b1;
        reset_t = 1'b1;

        $display("[TB] reset hold and release");
        applyStimulus(5);
        reset = 1'b0;
        applyStimulus(3000);

        $display("[TB] asynchronous resets at random points");
        for (int r = 0; r < 3; r++) begin
            applyStimulus(int'($urandom_range(40, 600)));
            @(posedge clock);
            if (!reset) edges++;
            #($urandom_range(1, 8));
            reset = 1'b1;
            edges = 0;
            #1;
            checkOutput();
            applyStimulus(int'($urandom_range(1, 4)));
            reset = 1'b0;
            applyStimulus(1200);
        end

        $display("[TB] frame_count wrap on one-pixel frames");
        repeat (3) @(negedge clock_t);
        checkTiny();
        reset_t = 1'b0;
        for (int k = 1; k <= 65537; k++) begin
            @(posedge clock_t);
            edges_t++;
            if (k <= 3 || k >= 65535) begin
                @(negedge clock_t);
                checkTiny();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
